sync_stab: RTL and testbench
============================

// Module: sync_stab
// PURPOSE
//   Multi-flop synchronizer bringing asynchronous single- or multi-bit level signals
//   (e.g. TX enable) into the CLKip domain.
//   Optional per-bit glitch filter and one-cycle rise/fall pulse outputs.
//   Instantiated in front of every asynchronous control input of the UART blocks.
// PARAMETERS
//   STAGES         2   synchronizer flop depth; values < 2 are an elaboration error
//   WIDTH          1   number of independent bits synchronized (no bus coherency implied)
//   RESET_VAL      0   value (replicated per bit) loaded into every flop on reset
//   STABLE_CYCLES  0   glitch filter length in CLKip cycles; 0 = filter bypassed
// PORTS
//   CLKip  in   1      clock, rising-edge
//   RSTi   in   1      asynchronous reset, active-high; tie 0 when synchronizing a reset
//   SIGi   in   WIDTH  asynchronous input level(s)
//   SIGo   out  WIDTH  synchronized (and filtered) level(s)
//   RISEo  out  WIDTH  1-cycle pulse per bit on SIGo 0->1
//   FALLo  out  WIDTH  1-cycle pulse per bit on SIGo 1->0
// BEHAVIOUR
//   - Reset (RSTi=1, async):
//     - all sync flops, filter outputs and edge-history flops <= RESET_VAL; filter counters <= 0.
//     - SIGo = RESET_VAL; RISEo = FALLo = 0.
//     - No edge pulse is produced on reset entry or release.
//   - Sync chain, per bit:
//     - stage[0] <= SIGi on each posedge; stage[k] <= stage[k-1].
//     - The synced value s = stage[STAGES-1].
//   - Filter (STABLE_CYCLES=0): SIGo = s; a SIGi change stable across a clock edge reaches
//     SIGo after exactly STAGES posedges.
//   - Filter (STABLE_CYCLES=N>0), per bit, registered out and counter cnt
//     (width clog2(N+1)):
//     - s == out: cnt <= 0.
//     - s != out and cnt == N-1: out <= s, cnt <= 0.
//     - otherwise: cnt <= cnt+1.
//     - SIGo = out. Latency = STAGES+N edges.
//     - A pulse on s shorter than N cycles never reaches SIGo and clears cnt when it ends.
//   - Edges:
//     - prev <= SIGo each posedge.
//     - RISEo = SIGo & ~prev; FALLo = ~SIGo & prev (combinational).
//     - Each pulse is high for exactly the first cycle of the new SIGo level.
//   - Bits are fully independent; WIDTH>1 gives no cross-bit coherency.
//     Multi-bit data buses must not use this block.
//   - Reset mid-operation: pending filter counts are discarded; after release the chain
//     refills from SIGi with the normal latency. An edge is reported only if the new
//     SIGo differs from RESET_VAL.
//   - Metastability: stage[0] may resolve either way. A SIGi change within setup/hold
//     costs at most 1 extra cycle of latency, never an intermediate SIGo value.
// TESTING
//   1. Defaults: RSTi pulse -> SIGo=0, RISEo=FALLo=0. SIGi 0->1 before edge e ->
//      SIGo=1 after edge e+1; RISEo=1 for that single cycle.
//   2. STAGES=3: SIGi 1->0 -> SIGo=0 after 3rd posedge; FALLo one cycle only; no RISEo.
//   3. STABLE_CYCLES=4: 3-cycle SIGi high pulse -> SIGo stays 0, no RISEo.
//      5-cycle pulse -> SIGo=1 at STAGES+4 edges after onset.
//   4. RESET_VAL=1: reset -> SIGo=1, no FALLo.
//      SIGi held 1 through release -> no pulses.
//      SIGi=0 -> FALLo single pulse.
//   5. WIDTH=4: SIGi 4'b0000->4'b0101 -> SIGo=4'b0101 after STAGES edges,
//      RISEo=4'b0101 for one cycle, FALLo=0.
//   6. RSTi asserted mid-count (STABLE_CYCLES=4, after 2 cycles) -> SIGo=RESET_VAL
//      immediately, without waiting for a clock.
//      After release with SIGi=1 -> SIGo=1 after STAGES+4 edges.

Source files
------------

// File: rtl/sync_stab.sv
// rtl/sync_stab.sv - multi-flop level synchronizer with optional glitch filter and edge pulses
//
// Each bit is handled independently: a STAGES-deep flop chain brings SIGi into
// the CLKip domain, an optional per-bit stability filter suppresses pulses
// shorter than STABLE_CYCLES, and a history flop turns level changes on SIGo
// into one-cycle RISEo / FALLo pulses. Bits share no coherency, so a multi-bit
// data bus must never be passed through this block.
module sync_stab #(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned WIDTH         = 1,
  parameter bit          RESET_VAL     = 1'b0,
  parameter int unsigned STABLE_CYCLES = 0
) (
  input  logic             CLKip,
  input  logic             RSTi,
  input  logic [WIDTH-1:0] SIGi,
  output logic [WIDTH-1:0] SIGo,
  output logic [WIDTH-1:0] RISEo,
  output logic [WIDTH-1:0] FALLo
);

  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

  // A chain of fewer than two flops cannot resolve metastability.
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_stab: STAGES must be at least 2");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_stab: WIDTH must be at least 1");
  end

  // stage[0] may go metastable; later stages give it time to settle.
  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;

  // Shift SIGi through the synchronizer chain every clock.
  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage[k] <= RST_VEC;
      end
    end else begin
      stage[0] <= SIGi;
      for (int k = 1; k < int'(STAGES); k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign synced = stage[STAGES-1];

  if (STABLE_CYCLES == 0) begin : g_no_filter
    // No filtering: the synchronized level is the output level.
    assign filt = synced;
  end else begin : g_filter
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             out_q;

      // Count consecutive cycles the synced level disagrees with the output;
      // adopt the new level only after STABLE_CYCLES disagreeing cycles.
      always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
          cnt   <= '0;
          out_q <= RESET_VAL;
        end else if (synced[b] == out_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          out_q <= synced[b];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign filt[b] = out_q;
    end
  end

  assign SIGo = filt;

  // Remember last cycle's output so level changes can be flagged.
  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      prev <= RST_VEC;
    end else begin
      prev <= SIGo;
    end
  end

  // Pulses are high only during the first cycle of a new SIGo level.
  assign RISEo = SIGo & ~prev;
  assign FALLo = ~SIGo & prev;

endmodule

// File: tb/tb_sync_stab.sv
// tb/tb_sync_stab.sv - randomized bench for sync_stab across several configurations
module tb_sync_stab;

  localparam int NDUT = 6;
  localparam int HMAX = 4096;

  // Per-instance configuration: stages, width, reset value, filter length.
  int st_c [NDUT] = '{2, 3, 2, 3, 2, 4};
  int w_c  [NDUT] = '{1, 1, 4, 2, 4, 3};
  int rv_c [NDUT] = '{0, 0, 0, 1, 0, 1};
  int n_c  [NDUT] = '{0, 0, 4, 2, 0, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] si    [NDUT];
  logic [3:0] so_o  [NDUT];
  logic [3:0] ri_o  [NDUT];
  logic [3:0] fa_o  [NDUT];

  logic       so0, ri0, fa0;
  logic       so1, ri1, fa1;
  logic [3:0] so2, ri2, fa2;
  logic [1:0] so3, ri3, fa3;
  logic [3:0] so4, ri4, fa4;
  logic [2:0] so5, ri5, fa5;

  sync_stab #(.STAGES(2), .WIDTH(1), .RESET_VAL(1'b0), .STABLE_CYCLES(0)) u_d0 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[0][0:0]), .SIGo(so0), .RISEo(ri0), .FALLo(fa0));
  sync_stab #(.STAGES(3), .WIDTH(1), .RESET_VAL(1'b0), .STABLE_CYCLES(0)) u_d1 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[1][0:0]), .SIGo(so1), .RISEo(ri1), .FALLo(fa1));
  sync_stab #(.STAGES(2), .WIDTH(4), .RESET_VAL(1'b0), .STABLE_CYCLES(4)) u_d2 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[2][3:0]), .SIGo(so2), .RISEo(ri2), .FALLo(fa2));
  sync_stab #(.STAGES(3), .WIDTH(2), .RESET_VAL(1'b1), .STABLE_CYCLES(2)) u_d3 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[3][1:0]), .SIGo(so3), .RISEo(ri3), .FALLo(fa3));
  sync_stab #(.STAGES(2), .WIDTH(4), .RESET_VAL(1'b0), .STABLE_CYCLES(0)) u_d4 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[4][3:0]), .SIGo(so4), .RISEo(ri4), .FALLo(fa4));
  sync_stab #(.STAGES(4), .WIDTH(3), .RESET_VAL(1'b1), .STABLE_CYCLES(4)) u_d5 (
    .CLKip(clk), .RSTi(rst), .SIGi(si[5][2:0]), .SIGo(so5), .RISEo(ri5), .FALLo(fa5));

  // Gather the differently sized outputs into uniform 4-bit views.
  always_comb begin
    so_o[0] = {3'b000, so0}; ri_o[0] = {3'b000, ri0}; fa_o[0] = {3'b000, fa0};
    so_o[1] = {3'b000, so1}; ri_o[1] = {3'b000, ri1}; fa_o[1] = {3'b000, fa1};
    so_o[2] = so2;           ri_o[2] = ri2;           fa_o[2] = fa2;
    so_o[3] = {2'b00, so3};  ri_o[3] = {2'b00, ri3};  fa_o[3] = {2'b00, fa3};
    so_o[4] = so4;           ri_o[4] = ri4;           fa_o[4] = fa4;
    so_o[5] = {1'b0, so5};   ri_o[5] = {1'b0, ri5};   fa_o[5] = {1'b0, fa5};
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: input history since the last reset release, plus the
  // expected output level before and after the most recent edge.
  logic [3:0] hist [NDUT][HMAX];
  int         hlen;
  logic [3:0] m_out  [NDUT];
  logic [3:0] m_rise [NDUT];
  logic [3:0] m_fall [NDUT];
  int         hold   [NDUT][4];

  function automatic logic [3:0] mask_of(input int d);
    return 4'((1 << w_c[d]) - 1);
  endfunction

  function automatic logic rv_vec_bit(input int d);
    return (rv_c[d] != 0);
  endfunction

  // Synced level seen just before edge k: input sampled STAGES edges earlier.
  function automatic logic s_before(input int d, input int b, input int k);
    int i;
    i = k - st_c[d];
    if (i < 0) return rv_vec_bit(d);
    return hist[d][i][b];
  endfunction

  // Synced level right after edge k.
  function automatic logic s_after(input int d, input int b, input int k);
    int i;
    i = k - st_c[d] + 1;
    if (i < 0) return rv_vec_bit(d);
    return hist[d][i][b];
  endfunction

  task automatic model_reset();
    hlen = 0;
    for (int d = 0; d < NDUT; d++) begin
      m_out[d]  = rv_c[d] != 0 ? mask_of(d) : 4'b0000;
      m_rise[d] = 4'b0000;
      m_fall[d] = 4'b0000;
    end
  endtask

  task automatic model_step();
    int m;
    m = hlen;
    for (int d = 0; d < NDUT; d++) hist[d][m] = si[d] & mask_of(d);
    hlen = hlen + 1;
    for (int d = 0; d < NDUT; d++) begin
      logic [3:0] nxt;
      nxt = m_out[d];
      for (int b = 0; b < w_c[d]; b++) begin
        if (n_c[d] == 0) begin
          nxt[b] = s_after(d, b, m);
        end else begin
          // Flip only if the synced level disagreed for the last N edges.
          logic flip;
          flip = 1'b1;
          for (int j = 0; j < n_c[d]; j++) begin
            if ((m - j) < 0 || s_before(d, b, m - j) == m_out[d][b]) flip = 1'b0;
          end
          if (flip) nxt[b] = ~m_out[d][b];
        end
      end
      m_rise[d] = nxt & ~m_out[d];
      m_fall[d] = ~nxt & m_out[d] & mask_of(d);
      m_out[d]  = nxt;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("sigo[%0d]", d), 32'(so_o[d] & mask_of(d)), 32'(m_out[d]));
      chk($sformatf("rise[%0d]", d), 32'(ri_o[d] & mask_of(d)), 32'(m_rise[d]));
      chk($sformatf("fall[%0d]", d), 32'(fa_o[d] & mask_of(d)), 32'(m_fall[d]));
    end
  endtask

  // Random levels held for 1..7 cycles give both sub-filter glitches and stable changes.
  task automatic drive();
    for (int d = 0; d < NDUT; d++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[d][b] == 0) begin
          si[d][b]   = (b < w_c[d]) ? 1'($urandom_range(0, 1)) : 1'b0;
          hold[d][b] = int'($urandom_range(1, 7));
        end
        hold[d][b] = hold[d][b] - 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      si[d] = (rv_c[d] != 0) ? mask_of(d) : 4'b0000;
      for (int b = 0; b < 4; b++) hold[d][b] = 3;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();

    for (int seg = 0; seg < 4; seg++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 400 + seg * 37; c++) begin
        drive();
        @(posedge clk);
        model_step();
        #1 check_all();
        @(negedge clk);
      end
      // Reset mid-operation, between clock edges: outputs must go to reset at once.
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1 check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
